// File: rtl/jtsbaskt_colmix_pkg.sv
// Shared constants and types for the jtsbaskt colour mixer.
// scr_pxl layout is {prio, pal[2:0], col[3:0]}.
package jtsbaskt_colmix_pkg;

  localparam logic [1:0] PROM_R = 2'd0;
  localparam logic [1:0] PROM_G = 2'd1;
  localparam logic [1:0] PROM_B = 2'd2;

  localparam int IDX_AW = 8;

  localparam int SCR_PRIO    = 7;
  localparam int SCR_PAL_MSB = 6;
  localparam int SCR_PAL_LSB = 4;
  localparam int SCR_COL_MSB = 3;
  localparam int SCR_COL_LSB = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Object entries live in the upper half of the palette, one 16-colour block per bank.
  function automatic logic [IDX_AW-1:0] obj_idx(input logic [2:0] bank, input logic [3:0] pxl);
    return {1'b1, bank, pxl};
  endfunction

endpackage

// File: rtl/jtsbaskt_colmix_palrom.sv
// Three 256x4 colour PROMs (R, G, B) loaded over the download bus,
// read through one shared address into a registered 12-bit colour.
module jtsbaskt_colmix_palrom
  import jtsbaskt_colmix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en_i,
  input  logic [IDX_AW-1:0] rd_addr_i,
  input  logic [1:0]        wr_sel_i,
  input  logic [IDX_AW-1:0] wr_addr_i,
  input  logic [3:0]        wr_data_i,
  input  logic              wr_en_i,
  output rgb_t              rd_data_o
);

  logic [3:0] memR [0:255];
  logic [3:0] memG [0:255];
  logic [3:0] memB [0:255];

  rgb_t rdData_q;

  // Contents are never reset, so a loaded palette survives a mid-frame reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      case (wr_sel_i)
        PROM_R:  memR[wr_addr_i] <= wr_data_i;
        PROM_G:  memG[wr_addr_i] <= wr_data_i;
        PROM_B:  memB[wr_addr_i] <= wr_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdData_q <= '0;
    end else if (rd_en_i) begin
      rdData_q <= '{r: memR[rd_addr_i], g: memG[rd_addr_i], b: memB[rd_addr_i]};
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/jtsbaskt_colmix.sv
// Colour mixer: object/scroll priority, palette PROM lookup and delayed blanking.
// Optional macro JTSBASKT_LAYER_EN enables the gfx_en debug layer masks.
module jtsbaskt_colmix
  import jtsbaskt_colmix_pkg::*;
#(
  parameter int BLNK_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [3:0] obj_pxl,
  input  logic [7:0] scr_pxl,
  input  logic [2:0] obj_bank,
  input  logic [1:0] gfx_en,
  input  logic [9:0] prog_addr,
  input  logic [3:0] prog_data,
  input  logic       prog_en,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic              objOp;
  logic              scrOp;
  logic              scrWin;
  logic [IDX_AW-1:0] idx_d;
  logic [IDX_AW-1:0] idx_q;
  logic [2:0]        bank_q;
  logic              lhblLast_q;
  logic [BLNK_DLY-1:0] hDly_q;
  logic [BLNK_DLY-1:0] vDly_q;
  rgb_t              romRgb;
  logic              videoOn;

`ifdef JTSBASKT_LAYER_EN
  assign objOp = (obj_pxl != 4'd0) & gfx_en[1];
  assign scrOp = (scr_pxl[SCR_COL_MSB:SCR_COL_LSB] != 4'd0) & gfx_en[0];
`else
  logic unusedGfx;
  assign unusedGfx = ^gfx_en;
  assign objOp = (obj_pxl != 4'd0);
  assign scrOp = (scr_pxl[SCR_COL_MSB:SCR_COL_LSB] != 4'd0);
`endif

  // A transparent object always yields to scroll, which also supplies the backdrop.
  assign scrWin = (scr_pxl[SCR_PRIO] & scrOp) | ~objOp;

  always_comb begin
    idx_d = obj_idx(bank_q, obj_pxl);
    if (scrWin) begin
      idx_d = {1'b0, scr_pxl[SCR_PAL_MSB:SCR_COL_LSB]};
    end
  end

  // The bank is only taken at the start of horizontal blank so a line never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q      <= '0;
      bank_q     <= '0;
      lhblLast_q <= 1'b0;
    end else if (pxl_cen) begin
      idx_q      <= idx_d;
      lhblLast_q <= LHBL;
      if (lhblLast_q && !LHBL) begin
        bank_q <= obj_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hDly_q <= '0;
      vDly_q <= '0;
    end else if (pxl_cen) begin
      hDly_q[0] <= LHBL;
      vDly_q[0] <= LVBL;
      for (int i = 1; i < BLNK_DLY; i++) begin
        hDly_q[i] <= hDly_q[i-1];
        vDly_q[i] <= vDly_q[i-1];
      end
    end
  end

  jtsbaskt_colmix_palrom u_palrom (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (pxl_cen),
    .rd_addr_i (idx_q),
    .wr_sel_i  (prog_addr[9:8]),
    .wr_addr_i (prog_addr[7:0]),
    .wr_data_i (prog_data),
    .wr_en_i   (prog_en),
    .rd_data_o (romRgb)
  );

  assign LHBL_dly = hDly_q[BLNK_DLY-1];
  assign LVBL_dly = vDly_q[BLNK_DLY-1];
  assign videoOn  = LHBL_dly & LVBL_dly;

  assign red   = videoOn ? romRgb.r : 4'd0;
  assign green = videoOn ? romRgb.g : 4'd0;
  assign blue  = videoOn ? romRgb.b : 4'd0;

endmodule

// File: tb/tb_jtsbaskt_colmix.sv
// Scoreboard bench for jtsbaskt_colmix: a palette/priority reference model predicts
// each pixel, and a monitor compares it when the DUT presents it two pxl_cen later.
module tb_jtsbaskt_colmix;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic       LVBL = 1'b1;
  logic [3:0] obj_pxl = 4'd0;
  logic [7:0] scr_pxl = 8'd0;
  logic [2:0] obj_bank = 3'd0;
  logic [1:0] gfx_en = 2'b11;
  logic [9:0] prog_addr = 10'd0;
  logic [3:0] prog_data = 4'd0;
  logic       prog_en = 1'b0;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  jtsbaskt_colmix #(.BLNK_DLY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .obj_pxl   (obj_pxl),
    .scr_pxl   (scr_pxl),
    .obj_bank  (obj_bank),
    .gfx_en    (gfx_en),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_en   (prog_en),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .LHBL_dly  (LHBL_dly),
    .LVBL_dly  (LVBL_dly)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       h;
    logic       v;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  exp_t       expQ[$];
  exp_t       lastExp;
  bit         haveExp = 0;
  int         checks = 0;
  int         fails = 0;
  logic [3:0] promModel[3][256];
  logic [2:0] bankModel = 3'd0;
  bit         lhblPrev = 0;
  logic [7:0] lastIdx = 8'd0;

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Palette index from the priority rules, in plain arithmetic.
  function automatic logic [7:0] refIdx(input logic [3:0] obj, input logic [7:0] scr,
                                        input logic [2:0] bank, input logic [1:0] gfx);
    bit objShown = int'(obj) != 0;
    bit scrShown = (int'(scr) % 16) != 0;
    bit scrPrio  = int'(scr) >= 128;
    bit layerOn;
`ifdef JTSBASKT_LAYER_EN
    layerOn = 1;
`else
    layerOn = 0;
`endif
    if (layerOn && !gfx[1]) objShown = 0;
    if (layerOn && !gfx[0]) scrShown = 0;
    if (objShown && !(scrPrio && scrShown))
      return 8'(128 + int'(bank) * 16 + int'(obj));
    return 8'(int'(scr) % 128);
  endfunction

  task automatic progWrite(input logic [1:0] sel, input logic [7:0] addr, input logic [3:0] data);
    @(negedge clk);
    prog_en   = 1'b1;
    prog_addr = {sel, addr};
    prog_data = data;
    if (sel != 2'd3) promModel[sel][addr] = data;
    @(negedge clk);
    prog_en = 1'b0;
  endtask

  // One pixel on a pxl_cen pulse, optionally with a PROM write on the same clock,
  // followed by 'gap' frozen clocks with scrambled pixel inputs.
  task automatic applyStimulus(input logic [3:0] obj, input logic [7:0] scr, input logic [2:0] bank,
                               input logic h, input logic v, input logic [1:0] gfx,
                               input bit wr, input logic [9:0] wa, input logic [3:0] wd, input int gap);
    exp_t e;
    logic [7:0] idx;
    @(negedge clk);
    obj_pxl   = obj;
    scr_pxl   = scr;
    obj_bank  = bank;
    LHBL      = h;
    LVBL      = v;
    gfx_en    = gfx;
    prog_en   = wr;
    prog_addr = wa;
    prog_data = wd;
    pxl_cen   = 1'b1;
    if (wr && wa[9:8] != 2'd3) promModel[wa[9:8]][wa[7:0]] = wd;
    idx = refIdx(obj, scr, bankModel, gfx);
    lastIdx = idx;
    e.h = h;
    e.v = v;
    if (h && v) begin
      e.r = promModel[0][idx];
      e.g = promModel[1][idx];
      e.b = promModel[2][idx];
    end else begin
      e.r = 4'd0;
      e.g = 4'd0;
      e.b = 4'd0;
    end
    expQ.push_back(e);
    if (lhblPrev && !h) bankModel = bank;
    lhblPrev = h;
    @(negedge clk);
    pxl_cen = 1'b0;
    prog_en = 1'b0;
    repeat (gap) begin
      obj_pxl = 4'($urandom);
      scr_pxl = 8'($urandom);
      LHBL    = 1'($urandom);
      LVBL    = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n   = 1'b0;
    pxl_cen = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_outputs", {LHBL_dly, LVBL_dly, red, green, blue}, 14'd0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    expQ.delete();
    haveExp   = 0;
    bankModel = 3'd0;
    lhblPrev  = 0;
  endtask

  // Monitor: a pixel is presented on every pxl_cen; frozen clocks must hold it.
  always @(posedge clk) begin
    if (rst_n && pxl_cen) begin
      #1;
      if (expQ.size() >= 2) begin
        lastExp = expQ.pop_front();
        checkOutput("pixel", {LHBL_dly, LVBL_dly, red, green, blue}, lastExp);
        haveExp = 1;
      end
    end else if (rst_n && !prog_en && haveExp) begin
      #1;
      checkOutput("freeze", {LHBL_dly, LVBL_dly, red, green, blue}, lastExp);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    repeat (2) @(negedge clk);
    applyReset();

    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 256; a++)
        progWrite(2'(s), 8'(a), 4'($urandom));
    progWrite(2'd0, 8'h85, 4'hF);
    progWrite(2'd1, 8'h85, 4'h0);
    progWrite(2'd2, 8'h85, 4'h5);
    progWrite(2'd0, 8'h13, 4'h1);
    progWrite(2'd1, 8'h13, 4'h2);
    progWrite(2'd2, 8'h13, 4'h3);
    progWrite(2'd0, 8'h20, 4'h4);
    progWrite(2'd1, 8'h20, 4'h6);
    progWrite(2'd2, 8'h20, 4'h8);
    progWrite(2'd0, 8'hB5, 4'hA);
    progWrite(2'd1, 8'hB5, 4'hB);
    progWrite(2'd2, 8'hB5, 4'hC);
    progWrite(2'd3, 8'h85, 4'h0);

    $display("[TB] directed: object over transparent scroll");
    repeat (3) applyStimulus(4'd5, 8'h00, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    $display("[TB] directed: scroll priority");
    repeat (2) applyStimulus(4'd5, 8'h93, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 1);
    repeat (2) applyStimulus(4'd5, 8'h13, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    $display("[TB] directed: backdrop");
    applyStimulus(4'd0, 8'h20, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    applyStimulus(4'd0, 8'hA0, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 2);
    $display("[TB] directed: bank latch and blank pulse");
    repeat (3) applyStimulus(4'd5, 8'h00, 3'd3, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    applyStimulus(4'd5, 8'h00, 3'd3, 1'b0, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    repeat (3) applyStimulus(4'd5, 8'h00, 3'd3, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 3);
    $display("[TB] directed: read during write of the same entry");
    applyStimulus(4'd5, 8'h00, 3'd3, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    applyStimulus(4'd0, 8'h20, 3'd3, 1'b1, 1'b1, 2'b11, 1, {2'd0, 8'hB5}, 4'h7, 0);
    repeat (2) applyStimulus(4'd5, 8'h00, 3'd3, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);

    $display("[TB] directed: reset mid-frame");
    applyReset();
    repeat (3) applyStimulus(4'd5, 8'h00, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);
    repeat (3) applyStimulus(4'd5, 8'h13, 3'd0, 1'b1, 1'b1, 2'b01, 0, 10'd0, 4'd0, 0);
    repeat (2) applyStimulus(4'd5, 8'h93, 3'd0, 1'b1, 1'b1, 2'b10, 0, 10'd0, 4'd0, 0);

    $display("[TB] random pixels");
    for (int n = 0; n < 400; n++) begin
      logic [3:0] o;
      logic [7:0] s;
      bit         w;
      logic [9:0] wa;
      t  = n % 24;
      o  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      s  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) s[3:0] = 4'd0;
      w  = ($urandom_range(0, 9) == 0);
      wa = {2'($urandom), ($urandom_range(0, 1) == 0) ? lastIdx : 8'($urandom)};
      applyStimulus(o, s, 3'($urandom), 1'(t >= 3), 1'(((n / 24) % 6) != 0), 2'($urandom),
                    w, wa, 4'($urandom), int'($urandom_range(0, 2)));
    end
    repeat (2) applyStimulus(4'd0, 8'h20, 3'd0, 1'b1, 1'b1, 2'b11, 0, 10'd0, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
